// File: rtl/alu_pkg.sv
// Shared opcode encodings and control-bit positions for the Hack-style ALU.
// The operation word is {zx, nx, zy, ny, f, no}, with zx in bit 5.
package alu_pkg;

    localparam int OP_W = 6;

    localparam int BIT_ZX = 5;
    localparam int BIT_NX = 4;
    localparam int BIT_ZY = 3;
    localparam int BIT_NY = 2;
    localparam int BIT_F  = 1;
    localparam int BIT_NO = 0;

    localparam logic [OP_W-1:0] OP_ZERO = 6'b101010;
    localparam logic [OP_W-1:0] OP_ONE  = 6'b111111;
    localparam logic [OP_W-1:0] OP_NEG1 = 6'b111010;
    localparam logic [OP_W-1:0] OP_X    = 6'b001100;
    localparam logic [OP_W-1:0] OP_Y    = 6'b110000;
    localparam logic [OP_W-1:0] OP_NOTX = 6'b001101;
    localparam logic [OP_W-1:0] OP_NOTY = 6'b110001;
    localparam logic [OP_W-1:0] OP_NEGX = 6'b001111;
    localparam logic [OP_W-1:0] OP_NEGY = 6'b110011;
    localparam logic [OP_W-1:0] OP_XP1  = 6'b011111;
    localparam logic [OP_W-1:0] OP_YP1  = 6'b110111;
    localparam logic [OP_W-1:0] OP_XM1  = 6'b001110;
    localparam logic [OP_W-1:0] OP_YM1  = 6'b110010;
    localparam logic [OP_W-1:0] OP_ADD  = 6'b000010;
    localparam logic [OP_W-1:0] OP_XMY  = 6'b010011;
    localparam logic [OP_W-1:0] OP_YMX  = 6'b000111;
    localparam logic [OP_W-1:0] OP_AND  = 6'b000000;
    localparam logic [OP_W-1:0] OP_OR   = 6'b010101;

endpackage

// File: rtl/alu_core.sv
// Combinational Hack ALU datapath: per-operand zero/invert, add or AND,
// optional output invert, plus zero and negative flags on the result.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [OP_W-1:0]  operation,
    output logic [WIDTH-1:0] res,
    output logic             zr,
    output logic             ng
);

    logic [WIDTH-1:0] xa;
    logic [WIDTH-1:0] xb;
    logic [WIDTH-1:0] ya;
    logic [WIDTH-1:0] yb;
    logic [WIDTH-1:0] r;

    always_comb begin
        xa  = operation[BIT_ZX] ? '0 : x;
        xb  = operation[BIT_NX] ? ~xa : xa;
        ya  = operation[BIT_ZY] ? '0 : y;
        yb  = operation[BIT_NY] ? ~ya : ya;
        // Carry out of the adder is dropped: arithmetic wraps modulo 2^WIDTH.
        r   = operation[BIT_F] ? (xb + yb) : (xb & yb);
        res = operation[BIT_NO] ? ~r : r;
        zr  = (res == '0);
        ng  = res[WIDTH-1];
    end

endmodule

// File: rtl/alu.sv
// Hack-style ALU with a single registered output stage and a valid pipe.
// Data registers hold their value while in_valid is low; out_valid tracks in_valid.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [OP_W-1:0]  operation,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             out_valid
);

    logic [WIDTH-1:0] res_p0;
    logic             zr_p0;
    logic             ng_p0;

    logic [WIDTH-1:0] res_p1;
    logic             zr_p1;
    logic             ng_p1;
    logic             vld_p1;

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .x         (x),
        .y         (y),
        .operation (operation),
        .res       (res_p0),
        .zr        (zr_p0),
        .ng        (ng_p0)
    );

    // Stage p0 -> p1: results are captured only for accepted inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_p1 <= '0;
            zr_p1  <= 1'b0;
            ng_p1  <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                res_p1 <= res_p0;
                zr_p1  <= zr_p0;
                ng_p1  <= ng_p0;
            end
        end
    end

    assign out       = res_p1;
    assign zr        = zr_p1;
    assign ng        = ng_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the registered Hack ALU: directed cases plus
// randomized traffic compared against an arithmetic reference model.
module tb_alu;
    import alu_pkg::*;

    localparam int W = 16;
    localparam int unsigned MAXV = (1 << W) - 1;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [5:0]   operation;
    logic [W-1:0] out;
    logic         zr;
    logic         ng;
    logic         out_valid;

    int checks;
    int failures;

    logic [W-1:0] e_out;
    logic         e_zr;
    logic         e_ng;

    alu #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .operation (operation),
        .out       (out),
        .zr        (zr),
        .ng        (ng),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: treat operands as integers in [0, 2^W); inversion is MAXV - v.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [5:0] op);
        int unsigned xv;
        int unsigned yv;
        int unsigned r;
        xv = op[5] ? 0 : int'(a);
        if (op[4]) xv = MAXV - xv;
        yv = op[3] ? 0 : int'(b);
        if (op[2]) yv = MAXV - yv;
        if (op[1]) r = (xv + yv) % (MAXV + 1);
        else       r = xv & yv;
        if (op[0]) r = MAXV - r;
        return r[W-1:0];
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [5:0] op);
        in_valid  = v;
        x         = a;
        y         = b;
        operation = op;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] eo, input logic ez,
                         input logic en, input logic ev);
        checks++;
        assert ({out, zr, ng, out_valid} === {eo, ez, en, ev})
        else begin
            failures++;
            $error("FAIL %s: got out=%h zr=%b ng=%b vld=%b, want out=%h zr=%b ng=%b vld=%b",
                   tag, out, zr, ng, out_valid, eo, ez, en, ev);
        end
    endtask

    typedef struct {
        logic [5:0]   op;
        logic [W-1:0] res;
        logic         neg;
    } sweep_t;

    sweep_t sweep[9];

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        x         = '0;
        y         = '0;
        operation = '0;

        sweep[0] = '{OP_ADD,  16'h0008, 1'b0};
        sweep[1] = '{OP_XMY,  16'h0002, 1'b0};
        sweep[2] = '{OP_YMX,  16'hFFFE, 1'b1};
        sweep[3] = '{OP_AND,  16'h0001, 1'b0};
        sweep[4] = '{OP_OR,   16'h0007, 1'b0};
        sweep[5] = '{OP_NEGX, 16'hFFFB, 1'b1};
        sweep[6] = '{OP_NOTX, 16'hFFFA, 1'b1};
        sweep[7] = '{OP_XP1,  16'h0006, 1'b0};
        sweep[8] = '{OP_YM1,  16'h0002, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("reset_init", 16'h0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 16'h0005, 16'h0003, sweep[i].op);
            check($sformatf("sweep_%0d", i), sweep[i].res, 1'b0, sweep[i].neg, 1'b1);
        end

        drive(1'b1, 16'h1234, 16'hABCD, OP_ZERO);
        check("const_zero", 16'h0000, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 16'h1234, 16'hABCD, OP_ONE);
        check("const_one", 16'h0001, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 16'h1234, 16'hABCD, OP_NEG1);
        check("const_neg1", 16'hFFFF, 1'b0, 1'b1, 1'b1);

        drive(1'b1, 16'hFFFF, 16'h0001, OP_ADD);
        check("wrap_add", 16'h0000, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 16'h7FFF, 16'h0000, OP_XP1);
        check("wrap_xp1", 16'h8000, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 16'h8000, 16'h0000, OP_NEGX);
        check("wrap_negx", 16'h8000, 1'b0, 1'b1, 1'b1);

        drive(1'b0, 16'h0001, 16'h0001, OP_ADD);
        check("hold_1", 16'h8000, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 16'h0000, 16'h0000, OP_ZERO);
        check("hold_2", 16'h8000, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 16'h0005, 16'h0003, OP_ADD);
        check("hold_resume", 16'h0008, 1'b0, 1'b0, 1'b1);

        e_out = 16'h0008;
        e_zr  = 1'b0;
        e_ng  = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            logic         v;
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic [5:0]   op;
            v  = ($urandom_range(0, 3) != 0);
            a  = W'($urandom);
            b  = W'($urandom);
            op = 6'($urandom_range(0, 63));
            drive(v, a, b, op);
            if (v) begin
                e_out = model(a, b, op);
                e_zr  = (e_out == 0);
                e_ng  = (e_out >= 16'h8000);
            end
            check($sformatf("rand_%0d", i), e_out, e_zr, e_ng, v);
        end

        drive(1'b1, 16'h0005, 16'h0003, OP_YMX);
        check("pre_reset", 16'hFFFE, 1'b0, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", 16'h0000, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
